mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Sits directly downstream of the multicycle main controller, between it and the shared single-port instruction/data memory.
- Turns the controller's fetch (IRWrite), load (adrSrc with memWrite=0) and store (adrSrc with memWrite=1) cycles into a req/ack memory handshake.
- Holds the instruction register (IR), the old-PC register and the memory data register (MDR).
- Raises stall so the controller freezes its state register until the access completes.
- Also detects memory timeouts.

Parameters:
- DW, 16, data/instruction width.
- AW, 16, memory address width.
- TIMEOUT, 15, maximum WAIT cycles before abort (1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- ir_write  in  1  controller IRWrite (fetch request).
- adr_src  in  1  controller adrSrc; 0 = PC address, 1 = ALU-result address.
- mem_write  in  1  controller memWrite.
- pc  in  AW  current PC.
- alu_result  in  AW  data address for loads/stores.
- write_data  in  DW  store data (rs2 register).
- mem_req  out  1  memory request, registered.
- mem_we  out  1  memory write enable, registered.
- mem_addr  out  AW  memory address, registered.
- mem_wdata  out  DW  memory write data, registered.
- mem_rdata  in  DW  memory read data, valid with mem_ack.
- mem_ack  in  1  memory completion, single-cycle pulse.
- instr  out  DW  IR contents.
- old_pc  out  AW  PC of the instruction held in IR.
- data_reg  out  DW  MDR contents.
- stall  out  1  controller must hold its state while high.
- mem_err  out  1  sticky timeout flag.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, instr=0, old_pc=0, data_reg=0, mem_err=0, wait counter=0. Reset mid-access drops mem_req immediately; the memory must tolerate an abandoned request.
- Access decode, sampled in IDLE only:
  - fetch = ir_write.
  - store = adr_src & mem_write & ~ir_write.
  - load = adr_src & ~mem_write & ~ir_write.
  - Fetch has priority over everything.
  - adr_src=0 without ir_write is not an access.
- FSM states: IDLE, WAIT, DONE.
- IDLE, with an access decoded:
  - Register mem_addr (pc for fetch, alu_result otherwise), mem_we=store, mem_wdata=write_data (store only; else hold).
  - Set mem_req=1, load the access kind, clear the counter, go to WAIT.
  - Capture pc into an internal fetch-PC holding register on fetch.
- WAIT:
  - mem_req=1; mem_addr, mem_we and mem_wdata stay stable.
  - On mem_ack:
    - Fetch: instr<=mem_rdata, old_pc<=captured PC.
    - Load: data_reg<=mem_rdata.
    - Store: no register update.
    - Then mem_req<=0, mem_we<=0, go to DONE.
  - Without ack: counter increments. When it reaches TIMEOUT, abort: mem_req<=0, mem_err<=1 (sticky until reset), instr<=0 on fetch, data_reg<=0 on load, go to DONE.
- DONE: one cycle, then IDLE. No access is decoded in DONE, so the same controller state is never re-issued.
- stall is combinational: stall = (IDLE & access decoded) | WAIT. It is 0 in DONE, so the controller advances on the DONE clock edge.
- Minimum access: 3 cycles (IDLE detect, WAIT with ack, DONE), stall high for 2 cycles.
- mem_ack outside WAIT is ignored (spurious): no register changes.
- mem_ack in the same cycle the counter reaches TIMEOUT: ack wins, no error.
- mem_rdata is sampled only when mem_ack=1.
- instr, old_pc and data_reg hold their values between accesses.
- Non-access controller states: stall=0, outputs unchanged.

Decomposition:
- Shared package:
  - FSM state encodings: IDLE, WAIT, DONE.
  - Access-kind constants: FETCH, LOAD, STORE.
  - Widths DW=16, AW=16.
  - Default TIMEOUT.
- One natural sub-module, mem_timeout_counter: clear, enable, terminal-count output, TIMEOUT parameter.
- IR, old-PC and MDR registers stay in the top level.

Test Plan:
- Fetch, ack after 1 WAIT cycle: ir_write=1, pc=16'h0010, mem_rdata=16'hA5C3 with ack.
  -> mem_addr=16'h0010, mem_we=0; instr=16'hA5C3 and old_pc=16'h0010 in DONE; stall high exactly 2 cycles.
- Load, ack after 4 cycles: adr_src=1, mem_write=0, alu_result=16'h0200, rdata=16'h1234.
  -> data_reg=16'h1234; instr unchanged; stall high 5 cycles.
- Store: adr_src=1, mem_write=1, alu_result=16'h0300, write_data=16'hBEEF, write_data changed mid-WAIT.
  -> mem_we=1 and mem_wdata=16'hBEEF stable until ack; data_reg unchanged.
- Timeout: fetch with ack never asserted, TIMEOUT=15.
  -> mem_req drops after 15 WAIT cycles; mem_err=1; instr=0. A following acked access still completes and mem_err stays 1.
- Boundaries:
  - ack in the TIMEOUT cycle -> success, mem_err=0.
  - Spurious ack in IDLE -> no change.
  - ir_write=1 with adr_src=1 and mem_write=1 -> treated as fetch, mem_we=0.
- Reset asserted mid-WAIT -> mem_req=0, stall=0, all registers 0 immediately. After release, the next fetch works normally.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the memory access unit that sits between
// the multicycle controller and the single-port instruction/data memory.
package mem_access_unit_pkg;

  localparam int unsigned DW          = 16;
  localparam int unsigned AW          = 16;
  localparam int unsigned TIMEOUT_DEF = 15;
  localparam int unsigned CNT_W       = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ACC_FETCH = 2'd0,
    ACC_LOAD  = 2'd1,
    ACC_STORE = 2'd2
  } acc_kind_e;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mem_cmd_t;

  // Only meaningful when an access is decoded (ir_write | adr_src); fetch wins.
  function automatic acc_kind_e decode_kind(input logic ir_write, input logic mem_write);
    if (ir_write)       return ACC_FETCH;
    else if (mem_write) return ACC_STORE;
    else                return ACC_LOAD;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Controller-side and memory-side signals of the memory access unit.
// master = the access unit, slave = controller plus memory.
interface mem_access_unit_if;
  import mem_access_unit_pkg::*;

  logic          ir_write;
  logic          adr_src;
  logic          mem_write;
  logic [AW-1:0] pc;
  logic [AW-1:0] alu_result;
  logic [DW-1:0] write_data;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic [DW-1:0] instr;
  logic [AW-1:0] old_pc;
  logic [DW-1:0] data_reg;
  logic          stall;
  logic          mem_err;

  modport master (
    input  ir_write, adr_src, mem_write, pc, alu_result, write_data,
    input  mem_rdata, mem_ack,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output instr, old_pc, data_reg, stall, mem_err
  );

  modport slave (
    output ir_write, adr_src, mem_write, pc, alu_result, write_data,
    output mem_rdata, mem_ack,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  instr, old_pc, data_reg, stall, mem_err
  );

endinterface

// File: rtl/mem_access_unit_timeout_counter.sv
// WAIT-cycle counter; terminal count flags the last WAIT cycle allowed
// before an access is abandoned.
module mem_timeout_counter
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc_c
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Count holds the number of WAIT cycles already spent without ack.
  assign o_tc_c = (r_cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_unit.sv
// Converts controller fetch/load/store cycles into a req/ack memory handshake,
// holds IR, old-PC and MDR, stalls the controller and flags memory timeouts.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  mem_access_unit_if.master  bus
);

  state_e        r_state, w_state_nxt;
  acc_kind_e     r_kind, w_kind;
  mem_cmd_t      r_cmd;
  logic          r_req;
  logic          r_err;
  logic [AW-1:0] r_fetch_pc;
  logic [AW-1:0] r_old_pc;
  logic [DW-1:0] r_instr;
  logic [DW-1:0] r_mdr;

  logic w_fetch, w_store, w_access;
  logic w_start, w_ack, w_abort, w_cnt_clr, w_cnt_en, w_tc;

  assign w_fetch  = bus.ir_write;
  assign w_store  = bus.adr_src & bus.mem_write & ~bus.ir_write;
  assign w_access = bus.ir_write | bus.adr_src;
  assign w_kind   = decode_kind(bus.ir_write, bus.mem_write);

  mem_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_cnt_clr),
    .i_en   (w_cnt_en),
    .o_tc_c (w_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Ack is checked before the timeout so a last-cycle ack still succeeds.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_ack       = 1'b0;
    w_abort     = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_en    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_access) begin
          w_start     = 1'b1;
          w_cnt_clr   = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.mem_ack) begin
          w_ack       = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_en = 1'b1;
          if (w_tc) begin
            w_abort     = 1'b1;
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req      <= 1'b0;
      r_cmd      <= '0;
      r_kind     <= ACC_FETCH;
      r_fetch_pc <= '0;
      r_old_pc   <= '0;
      r_instr    <= '0;
      r_mdr      <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_start) begin
        r_req      <= 1'b1;
        r_kind     <= w_kind;
        r_cmd.we   <= w_store;
        r_cmd.addr <= w_fetch ? bus.pc : bus.alu_result;
        if (w_store) r_cmd.wdata <= bus.write_data;
        if (w_fetch) r_fetch_pc  <= bus.pc;
      end
      if (w_ack) begin
        r_req    <= 1'b0;
        r_cmd.we <= 1'b0;
        if (r_kind == ACC_FETCH) begin
          r_instr  <= bus.mem_rdata;
          r_old_pc <= r_fetch_pc;
        end else if (r_kind == ACC_LOAD) begin
          r_mdr <= bus.mem_rdata;
        end
      end
      // Abandoned access: poison the destination register, error is sticky.
      if (w_abort) begin
        r_req    <= 1'b0;
        r_cmd.we <= 1'b0;
        r_err    <= 1'b1;
        if (r_kind == ACC_FETCH)     r_instr <= '0;
        else if (r_kind == ACC_LOAD) r_mdr   <= '0;
      end
    end
  end

  assign bus.mem_req   = r_req;
  assign bus.mem_we    = r_cmd.we;
  assign bus.mem_addr  = r_cmd.addr;
  assign bus.mem_wdata = r_cmd.wdata;
  assign bus.instr     = r_instr;
  assign bus.old_pc    = r_old_pc;
  assign bus.data_reg  = r_mdr;
  assign bus.mem_err   = r_err;
  // Held low during reset so a controller left mid-cycle is not frozen.
  assign bus.stall     = rst & (((r_state == S_IDLE) & w_access) | (r_state == S_WAIT));

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: fetch/load/store handshakes, timeouts,
// spurious acks, fetch priority and asynchronous reset mid-access.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  mem_access_unit_if bus();

  mem_access_unit #(.TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ctrl_idle();
    bus.ir_write  = 1'b0;
    bus.adr_src   = 1'b0;
    bus.mem_write = 1'b0;
  endtask

  // Runs one controller access from the IDLE detect cycle through DONE.
  // ack_cycle = WAIT cycle (1-based) carrying the ack, 0 = never.
  // Returns in the DONE cycle with controller inputs released.
  task automatic do_access(input string tag, input logic irw, input logic as,
                           input logic mw, input logic [15:0] a_pc,
                           input logic [15:0] a_alu, input logic [15:0] a_wd,
                           input int ack_cycle, input logic [15:0] rdata,
                           input logic exp_we, input logic [15:0] exp_addr,
                           output int stall_cnt, output int wait_n);
    logic stable;
    logic done;
    bus.ir_write   = irw;
    bus.adr_src    = as;
    bus.mem_write  = mw;
    bus.pc         = a_pc;
    bus.alu_result = a_alu;
    bus.write_data = a_wd;
    bus.mem_ack    = 1'b0;
    bus.mem_rdata  = 16'hDEAD;
    stall_cnt = 0;
    wait_n    = 0;
    stable    = 1'b1;
    done      = 1'b0;
    #1;
    if (bus.stall) stall_cnt++;
    chk({tag, " idle_req"}, 32'(bus.mem_req), 32'h0);
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(posedge clk);
      #1;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 16'hDEAD;
      #1;
      if (bus.stall) stall_cnt++;
      if (bus.mem_req) begin
        wait_n++;
        if (bus.mem_addr !== exp_addr || bus.mem_we !== exp_we ||
            (exp_we && bus.mem_wdata !== a_wd))
          stable = 1'b0;
        if (wait_n == 2) bus.write_data = ~a_wd;
        if (wait_n == ack_cycle) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = rdata;
        end
      end else if (wait_n > 0) begin
        done = 1'b1;
        chk({tag, " done_stall"}, 32'(bus.stall), 32'h0);
        ctrl_idle();
      end
    end
    chk({tag, " finished"}, 32'(done), 32'h1);
    chk({tag, " stable"}, 32'(stable), 32'h1);
  endtask

  int sc, wn;

  initial begin
    rst = 1'b0;
    ctrl_idle();
    bus.ir_write   = 1'b1;
    bus.pc         = 16'h0000;
    bus.alu_result = 16'h0000;
    bus.write_data = 16'h0000;
    bus.mem_rdata  = 16'h0000;
    bus.mem_ack    = 1'b0;
    tick();
    tick();
    chk("rst mem_req",   32'(bus.mem_req),   32'h0);
    chk("rst mem_we",    32'(bus.mem_we),    32'h0);
    chk("rst mem_addr",  32'(bus.mem_addr),  32'h0);
    chk("rst mem_wdata", 32'(bus.mem_wdata), 32'h0);
    chk("rst instr",     32'(bus.instr),     32'h0);
    chk("rst old_pc",    32'(bus.old_pc),    32'h0);
    chk("rst data_reg",  32'(bus.data_reg),  32'h0);
    chk("rst stall",     32'(bus.stall),     32'h0);
    chk("rst mem_err",   32'(bus.mem_err),   32'h0);
    ctrl_idle();
    rst = 1'b1;
    tick();

    // Fetch, ack in the first WAIT cycle
    do_access("fetch", 1, 0, 0, 16'h0010, 16'h0000, 16'h0000, 1, 16'hA5C3,
              1'b0, 16'h0010, sc, wn);
    chk("fetch stall_cycles", 32'(sc), 32'd2);
    chk("fetch instr",  32'(bus.instr),  32'h0000_A5C3);
    chk("fetch old_pc", 32'(bus.old_pc), 32'h0000_0010);
    tick();

    // Load, ack in the fourth WAIT cycle
    do_access("load", 0, 1, 0, 16'h0014, 16'h0200, 16'h0000, 4, 16'h1234,
              1'b0, 16'h0200, sc, wn);
    chk("load stall_cycles", 32'(sc), 32'd5);
    chk("load data_reg", 32'(bus.data_reg), 32'h0000_1234);
    chk("load instr",    32'(bus.instr),    32'h0000_A5C3);
    tick();

    // Store, write_data changes mid-WAIT
    do_access("store", 0, 1, 1, 16'h0018, 16'h0300, 16'hBEEF, 3, 16'h0F0F,
              1'b1, 16'h0300, sc, wn);
    chk("store stall_cycles", 32'(sc), 32'd4);
    chk("store data_reg", 32'(bus.data_reg), 32'h0000_1234);
    chk("store wdata",    32'(bus.mem_wdata), 32'h0000_BEEF);
    chk("store we_done",  32'(bus.mem_we),   32'h0);
    tick();

    // Spurious ack in IDLE
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 16'h5555;
    #1;
    chk("spur stall", 32'(bus.stall), 32'h0);
    tick();
    bus.mem_ack = 1'b0;
    chk("spur instr",    32'(bus.instr),    32'h0000_A5C3);
    chk("spur data_reg", 32'(bus.data_reg), 32'h0000_1234);
    chk("spur mem_req",  32'(bus.mem_req),  32'h0);
    chk("spur mem_addr", 32'(bus.mem_addr), 32'h0000_0300);

    // Ack in the same cycle the timeout would fire
    do_access("ack_tmo", 1, 0, 0, 16'h0020, 16'h0000, 16'h0000, 15, 16'h7777,
              1'b0, 16'h0020, sc, wn);
    chk("ack_tmo waits",   32'(wn), 32'd15);
    chk("ack_tmo instr",   32'(bus.instr),   32'h0000_7777);
    chk("ack_tmo old_pc",  32'(bus.old_pc),  32'h0000_0020);
    chk("ack_tmo mem_err", 32'(bus.mem_err), 32'h0);
    tick();

    // ir_write with a store pattern is a fetch
    do_access("prio", 1, 1, 1, 16'h0030, 16'h0400, 16'h1111, 2, 16'h3333,
              1'b0, 16'h0030, sc, wn);
    chk("prio instr",    32'(bus.instr),     32'h0000_3333);
    chk("prio old_pc",   32'(bus.old_pc),    32'h0000_0030);
    chk("prio data_reg", 32'(bus.data_reg),  32'h0000_1234);
    chk("prio wdata",    32'(bus.mem_wdata), 32'h0000_BEEF);
    tick();

    // Non-access controller state
    bus.mem_write = 1'b1;
    #1;
    chk("noacc stall", 32'(bus.stall), 32'h0);
    tick();
    chk("noacc mem_req", 32'(bus.mem_req), 32'h0);
    ctrl_idle();

    // Fetch timeout
    do_access("tmo_f", 1, 0, 0, 16'h0040, 16'h0000, 16'h0000, 0, 16'h0000,
              1'b0, 16'h0040, sc, wn);
    chk("tmo_f waits",   32'(wn), 32'd15);
    chk("tmo_f stall_cycles", 32'(sc), 32'd16);
    chk("tmo_f mem_err", 32'(bus.mem_err), 32'h1);
    chk("tmo_f instr",   32'(bus.instr),   32'h0);
    chk("tmo_f old_pc",  32'(bus.old_pc),  32'h0000_0030);
    tick();

    // Load timeout
    do_access("tmo_l", 0, 1, 0, 16'h0044, 16'h0480, 16'h0000, 0, 16'h0000,
              1'b0, 16'h0480, sc, wn);
    chk("tmo_l waits",    32'(wn), 32'd15);
    chk("tmo_l data_reg", 32'(bus.data_reg), 32'h0);
    tick();

    // Accesses after an error still complete; error stays set
    do_access("post_f", 1, 0, 0, 16'h0044, 16'h0000, 16'h0000, 1, 16'hC0DE,
              1'b0, 16'h0044, sc, wn);
    chk("post_f instr",   32'(bus.instr),   32'h0000_C0DE);
    chk("post_f old_pc",  32'(bus.old_pc),  32'h0000_0044);
    chk("post_f mem_err", 32'(bus.mem_err), 32'h1);
    tick();
    do_access("post_l", 0, 1, 0, 16'h0048, 16'h0500, 16'h0000, 1, 16'h4242,
              1'b0, 16'h0500, sc, wn);
    chk("post_l data_reg", 32'(bus.data_reg), 32'h0000_4242);
    chk("post_l mem_err",  32'(bus.mem_err),  32'h1);
    tick();

    // Asynchronous reset in the middle of WAIT
    bus.ir_write = 1'b1;
    bus.pc       = 16'h0050;
    tick();
    chk("mid_rst req_before", 32'(bus.mem_req), 32'h1);
    rst = 1'b0;
    #1;
    chk("mid_rst mem_req",  32'(bus.mem_req),   32'h0);
    chk("mid_rst stall",    32'(bus.stall),     32'h0);
    chk("mid_rst instr",    32'(bus.instr),     32'h0);
    chk("mid_rst old_pc",   32'(bus.old_pc),    32'h0);
    chk("mid_rst data_reg", 32'(bus.data_reg),  32'h0);
    chk("mid_rst mem_err",  32'(bus.mem_err),   32'h0);
    chk("mid_rst mem_addr", 32'(bus.mem_addr),  32'h0);
    chk("mid_rst wdata",    32'(bus.mem_wdata), 32'h0);
    ctrl_idle();
    tick();
    rst = 1'b1;
    tick();
    do_access("re_f", 1, 0, 0, 16'h0060, 16'h0000, 16'h0000, 1, 16'h9999,
              1'b0, 16'h0060, sc, wn);
    chk("re_f stall_cycles", 32'(sc), 32'd2);
    chk("re_f instr",   32'(bus.instr),   32'h0000_9999);
    chk("re_f old_pc",  32'(bus.old_pc),  32'h0000_0060);
    chk("re_f mem_err", 32'(bus.mem_err), 32'h0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
